// File: rtl/lutram_port_scheduler.sv
// Port scheduler for a write-A / read-B LUT RAM: round-robin arbitration of two
// write requesters, a pass-through read port, and a zero-fill flush sequencer.
module lutram_port_scheduler #(
  parameter int DATA_WIDTH      = 128,
  parameter int DATA_DEPTH_EXP2 = 8,
  parameter int ADDR_WIDTH      = DATA_DEPTH_EXP2
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  flush_req,
  output logic                  busy,
  output logic                  flush_done,

  input  logic                  w0_valid,
  output logic                  w0_ready,
  input  logic [ADDR_WIDTH-1:0] w0_addr,
  input  logic [DATA_WIDTH-1:0] w0_data,

  input  logic                  w1_valid,
  output logic                  w1_ready,
  input  logic [ADDR_WIDTH-1:0] w1_addr,
  input  logic [DATA_WIDTH-1:0] w1_data,

  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,

  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic                  ram_enb,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_doutb
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'((1 << DATA_DEPTH_EXP2) - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    last_grant_q, last_grant_d;
  logic                    flush_done_q, flush_done_d;
  logic                    rd_data_valid_q, rd_data_valid_d;

  logic                    is_idle;
  logic                    grant0;
  logic                    grant1;

  assign is_idle = (state_q == IDLE);

  // On a tie the requester that did not win last time is served.
  assign grant0 = is_idle & w0_valid & (~w1_valid | last_grant_q);
  assign grant1 = is_idle & w1_valid & (~w0_valid | ~last_grant_q);

  assign busy       = ~is_idle;
  assign flush_done = flush_done_q;
  assign w0_ready   = grant0;
  assign w1_ready   = grant1;
  assign rd_ready   = is_idle;

  assign ram_enb       = rd_valid & is_idle;
  assign ram_addrb     = rd_addr;
  assign rd_data_valid = rd_data_valid_q;
  assign rd_data       = rd_data_valid_q ? ram_doutb : '0;

  always_comb begin
    ram_ena   = 1'b0;
    ram_wea   = 1'b0;
    ram_addra = '0;
    ram_dina  = '0;
    if (state_q == FLUSH) begin
      ram_ena   = 1'b1;
      ram_wea   = 1'b1;
      ram_addra = cnt_q;
    end else if (grant0) begin
      ram_ena   = 1'b1;
      ram_wea   = 1'b1;
      ram_addra = w0_addr;
      ram_dina  = w0_data;
    end else if (grant1) begin
      ram_ena   = 1'b1;
      ram_wea   = 1'b1;
      ram_addra = w1_addr;
      ram_dina  = w1_data;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    last_grant_d    = last_grant_q;
    flush_done_d    = 1'b0;
    rd_data_valid_d = rd_valid & is_idle;

    if (grant0) begin
      last_grant_d = 1'b0;
    end else if (grant1) begin
      last_grant_d = 1'b1;
    end

    case (state_q)
      FLUSH: begin
        // A flush request here is deliberately dropped: the sweep already covers it.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d      = IDLE;
          flush_done_d = 1'b1;
        end
      end
      default: begin
        if (flush_req) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= FLUSH;
      cnt_q           <= '0;
      last_grant_q    <= 1'b1;
      flush_done_q    <= 1'b0;
      rd_data_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      last_grant_q    <= last_grant_d;
      flush_done_q    <= flush_done_d;
      rd_data_valid_q <= rd_data_valid_d;
    end
  end

endmodule

// File: tb/tb_lutram_port_scheduler.sv
// Scoreboard bench for lutram_port_scheduler with a write-first LUT RAM model
// on the RAM ports; expected port A writes and read data are queued at drive time.
module tb_lutram_port_scheduler;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk;
  logic          rst;
  logic          flush_req;
  logic          busy;
  logic          flush_done;
  logic          w0_valid, w0_ready;
  logic [AW-1:0] w0_addr;
  logic [DW-1:0] w0_data;
  logic          w1_valid, w1_ready;
  logic [AW-1:0] w1_addr;
  logic [DW-1:0] w1_data;
  logic          rd_valid, rd_ready;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          ram_ena, ram_wea, ram_enb;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dina, ram_doutb;

  lutram_port_scheduler #(
    .DATA_WIDTH      (DW),
    .DATA_DEPTH_EXP2 (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_req     (flush_req),
    .busy          (busy),
    .flush_done    (flush_done),
    .w0_valid      (w0_valid),
    .w0_ready      (w0_ready),
    .w0_addr       (w0_addr),
    .w0_data       (w0_data),
    .w1_valid      (w1_valid),
    .w1_ready      (w1_ready),
    .w1_addr       (w1_addr),
    .w1_data       (w1_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .ram_ena       (ram_ena),
    .ram_wea       (ram_wea),
    .ram_addra     (ram_addra),
    .ram_dina      (ram_dina),
    .ram_enb       (ram_enb),
    .ram_addrb     (ram_addrb),
    .ram_doutb     (ram_doutb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Write-first RAM: a same-cycle read of the written address returns the new data.
  logic [DW-1:0] mem [1<<AW];
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
    if (ram_enb) ram_doutb <= (ram_ena && ram_wea && ram_addra == ram_addrb) ? ram_dina : mem[ram_addrb];
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  logic [AW+DW-1:0] wq[$];
  logic [DW-1:0]    rq[$];

  // Reference model state
  logic          m_flush;
  logic [AW-1:0] m_cnt;
  logic          m_last;
  logic          m_fd;
  logic [DW-1:0] shadow [1<<AW];

  always @(negedge clk) begin
    if (!rst) begin
      if (ram_ena || ram_wea) chk("ena_eq_wea", {31'b0, ram_wea}, {31'b0, ram_ena});
      if (ram_ena && ram_wea) begin
        if (wq.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
        else begin
          logic [AW+DW-1:0] e;
          e = wq.pop_front();
          chk("wr_addr", {29'b0, ram_addra}, {29'b0, e[AW+DW-1:DW]});
          chk("wr_data", {24'b0, ram_dina}, {24'b0, e[DW-1:0]});
        end
      end
      if (rd_data_valid) begin
        if (rq.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
        else chk("rd_data", {24'b0, rd_data}, {24'b0, rq.pop_front()});
      end else begin
        chk("rd_data_zero", {24'b0, rd_data}, 32'd0);
      end
    end
  end

  task automatic cyc(input logic w0v, input logic [AW-1:0] w0a, input logic [DW-1:0] w0d,
                     input logic w1v, input logic [AW-1:0] w1a, input logic [DW-1:0] w1d,
                     input logic rv, input logic [AW-1:0] ra, input logic fr,
                     output logic fd_seen, output logic [1:0] gs);
    logic idle, g0, g1, nfd;
    w0_valid = w0v; w0_addr = w0a; w0_data = w0d;
    w1_valid = w1v; w1_addr = w1a; w1_data = w1d;
    rd_valid = rv;  rd_addr = ra;  flush_req = fr;
    idle = !m_flush;
    g0 = idle && w0v && (!w1v || m_last);
    g1 = idle && w1v && (!w0v || !m_last);
    if (!idle) begin
      wq.push_back({m_cnt, 8'h00});
      shadow[m_cnt] = '0;
    end else if (g0) begin
      wq.push_back({w0a, w0d});
      shadow[w0a] = w0d;
    end else if (g1) begin
      wq.push_back({w1a, w1d});
      shadow[w1a] = w1d;
    end
    if (rv && idle) rq.push_back(shadow[ra]);
    @(negedge clk);
    chk("w0_ready",   {31'b0, w0_ready},   {31'b0, g0});
    chk("w1_ready",   {31'b0, w1_ready},   {31'b0, g1});
    chk("rd_ready",   {31'b0, rd_ready},   {31'b0, idle});
    chk("busy",       {31'b0, busy},       {31'b0, !idle});
    chk("flush_done", {31'b0, flush_done}, {31'b0, m_fd});
    chk("ram_ena",    {31'b0, ram_ena},    {31'b0, (!idle || g0 || g1)});
    chk("ram_enb",    {31'b0, ram_enb},    {31'b0, (rv && idle)});
    fd_seen = flush_done;
    gs = {w1_ready, w0_ready};
    if (g0) m_last = 1'b0;
    if (g1) m_last = 1'b1;
    nfd = 1'b0;
    if (!idle) begin
      if (m_cnt == 3'd7) begin
        m_flush = 1'b0;
        nfd = 1'b1;
      end
      m_cnt = m_cnt + 3'd1;
    end else if (fr) begin
      m_flush = 1'b1;
      m_cnt = '0;
    end
    m_fd = nfd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc(input int n, output int fd_cnt);
    logic fd;
    logic [1:0] gs;
    fd_cnt = 0;
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, fd, gs);
      if (fd) fd_cnt++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    w0_valid = 0; w1_valid = 0; rd_valid = 0; flush_req = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy",     {31'b0, busy},          32'd1);
    chk("rst_rdv",      {31'b0, rd_data_valid}, 32'd0);
    chk("rst_done",     {31'b0, flush_done},    32'd0);
    chk("rst_w0_ready", {31'b0, w0_ready},      32'd0);
    chk("rst_rd_ready", {31'b0, rd_ready},      32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_flush = 1'b1;
    m_cnt = '0;
    m_last = 1'b1;
    m_fd = 1'b0;
    rq.delete();
  endtask

  initial begin
    logic fd;
    logic [1:0] gs;
    logic [7:0] seq;
    int n_fd, first_idx;

    rst = 1'b1;
    flush_req = 0; w0_valid = 0; w1_valid = 0; rd_valid = 0;
    w0_addr = 0; w0_data = 0; w1_addr = 0; w1_data = 0; rd_addr = 0;
    for (int i = 0; i < (1<<AW); i++) shadow[i] = '0;

    // Power-on flush with every requester asserted: none may be readied.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 1, 8'h11, 1, 6, 8'h66, 1, 0, 0, fd, gs);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, fd, gs);
    chk("init_flush_done", {31'b0, fd}, 32'd1);

    // Both writers valid: grants alternate starting with requester 0.
    seq = '0;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 2, 8'hAA, 1, 5, 8'h55, 0, 0, 0, fd, gs);
      seq = {seq[5:0], gs};
    end
    chk("alt_grants", {24'b0, seq}, 32'h66);
    cyc(0, 0, 0, 0, 0, 0, 1, 2, 0, fd, gs);
    cyc(0, 0, 0, 0, 0, 0, 1, 5, 0, fd, gs);
    idle_cyc(1, n_fd);

    // Same-cycle write and read of one address.
    cyc(0, 0, 0, 1, 3, 8'h3C, 1, 3, 0, fd, gs);
    idle_cyc(1, n_fd);

    // Flush request alongside a w0 write, then a second request mid-flush.
    n_fd = 0;
    cyc(1, 1, 8'h11, 0, 0, 0, 0, 0, 1, fd, gs);
    chk("pre_flush_w0_grant", {30'b0, gs}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, 8'h11, 0, 0, 0, 0, 0, (i == 3), fd, gs);
      if (fd) n_fd++;
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, fd, gs);
      if (fd) n_fd++;
    end
    chk("single_flush_done", n_fd, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 1, 2, 0, fd, gs);
    idle_cyc(1, n_fd);

    // Reset at flush counter 4 restarts the sweep from address 0.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, fd, gs);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, fd, gs);
    do_reset();
    first_idx = -1;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, fd, gs);
      if (fd && first_idx < 0) first_idx = i;
    end
    chk("rst_flush_done_idx", first_idx, 32'd8);

    // Lone w1 is served every cycle; a following tie goes to w0.
    seq = '0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 4, 8'h44, 0, 0, 0, fd, gs);
      seq = {seq[5:0], gs};
    end
    chk("w1_only_grants", {24'b0, seq}, 32'h2A);
    cyc(1, 6, 8'hC6, 1, 7, 8'hE7, 0, 0, 0, fd, gs);
    chk("tie_after_w1", {30'b0, gs}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 1, 6, 0, fd, gs);
    idle_cyc(2, n_fd);

    chk("wq_drained", wq.size(), 32'd0);
    chk("rq_drained", rq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
